// File: rtl/branch_predict_table.sv
// ============================================================================
//  Module   : branch_predict_table
//  Purpose  : Direct-mapped branch predictor for IF with ID-stage training,
//             selectable counter policy and a saturating mispredict counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predict_table #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 8,
    parameter int MODE    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        lk_valid,
    input  logic [31:0] lk_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [15:0] miss_count
);

    localparam logic [1:0] c_RESET_CTR = 2'b11;
    localparam logic [1:0] c_ALLOC_CTR = (MODE == 1) ? 2'b00 : 2'b01;

    logic                r_valid  [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    logic                r_pred_hit;
    logic                r_pred_taken;
    logic [31:0]         r_pred_target;
    logic [15:0]         r_miss_count;

    logic [IDX_W-1:0]    w_lk_idx;
    logic [TAG_W-1:0]    w_lk_tag;
    logic                w_lk_hit;
    logic [IDX_W-1:0]    w_up_idx;
    logic [TAG_W-1:0]    w_up_tag;
    logic                w_up_hit;
    logic [1:0]          w_up_ctr;
    logic [1:0]          w_ctr_next;
    logic                w_unused_pc;

    assign w_lk_idx = lk_pc[IDX_W+1:2];
    assign w_lk_tag = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Static mode never allocates, so a hit is impossible there.
    assign w_lk_hit = (MODE != 0) && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = r_ctr[w_up_idx];

    assign w_unused_pc = ^{lk_pc, upd_pc};

    always_comb begin
        w_ctr_next = w_up_ctr;
        case (MODE)
            1: w_ctr_next = upd_taken ? 2'b00 : 2'b11;
            3: begin
                // A miss in a weak state jumps straight to the opposite strong state.
                if (upd_taken) w_ctr_next = (w_up_ctr == 2'b11) ? 2'b10 : 2'b00;
                else           w_ctr_next = (w_up_ctr == 2'b00) ? 2'b01 : 2'b11;
            end
            default: begin
                if (upd_taken) w_ctr_next = (w_up_ctr == 2'b00) ? 2'b00 : w_up_ctr - 2'b01;
                else           w_ctr_next = (w_up_ctr == 2'b11) ? 2'b11 : w_up_ctr + 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_RESET_CTR;
            end
            r_pred_hit    <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_miss_count  <= '0;
        end else if (!stall) begin
            // Lookup reads the table before this edge's update lands.
            r_pred_hit    <= lk_valid && w_lk_hit;
            r_pred_taken  <= lk_valid && w_lk_hit && !r_ctr[w_lk_idx][1];
            r_pred_target <= (lk_valid && w_lk_hit) ? r_target[w_lk_idx] : 32'd0;

            if (upd_valid && (MODE != 0)) begin
                if (w_up_hit) begin
                    r_ctr[w_up_idx] <= w_ctr_next;
                    if (upd_taken) r_target[w_up_idx] <= upd_target;
                end else if (upd_taken) begin
                    r_valid[w_up_idx]  <= 1'b1;
                    r_tag[w_up_idx]    <= w_up_tag;
                    r_target[w_up_idx] <= upd_target;
                    r_ctr[w_up_idx]    <= c_ALLOC_CTR;
                end
            end

            if (upd_valid && upd_mispredict && (r_miss_count != 16'hFFFF))
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

    assign pred_hit    = r_pred_hit;
    assign pred_taken  = r_pred_taken;
    assign pred_target = r_pred_target;
    assign miss_count  = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_table.sv
// Bench for branch_predict_table: one instance per MODE driven in lockstep,
// checked against a strength-level reference model plus directed vectors.
`default_nettype none

module tb_branch_predict_table;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        lk_valid = 1'b0;
    logic [31:0] lk_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;

    logic        d_hit   [4];
    logic        d_taken [4];
    logic [31:0] d_tgt   [4];
    logic [15:0] d_miss  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        branch_predict_table #(.ENTRIES(16), .IDX_W(4), .TAG_W(8), .MODE(g)) u_dut (
            .clk(clk), .rst(rst), .stall(stall),
            .lk_valid(lk_valid), .lk_pc(lk_pc),
            .pred_hit(d_hit[g]), .pred_taken(d_taken[g]), .pred_target(d_tgt[g]),
            .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
            .upd_target(upd_target), .upd_mispredict(upd_mispredict),
            .miss_count(d_miss[g])
        );
    end

    // Reference model: level 3 = strongly taken ... 0 = strongly not-taken.
    bit          m_valid [4][16];
    int          m_tag   [4][16];
    logic [31:0] m_tgt   [4][16];
    int          m_lvl   [4][16];
    bit          e_hit   [4];
    bit          e_taken [4];
    logic [31:0] e_tgt   [4];
    int          e_miss;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int next_level(int m, int lvl, bit taken);
        if (m == 1) return taken ? 3 : 0;
        if (m == 2) return taken ? ((lvl < 3) ? lvl + 1 : 3) : ((lvl > 0) ? lvl - 1 : 0);
        if (taken) return (lvl == 0) ? 1 : 3;
        return (lvl == 3) ? 2 : 0;
    endfunction

    task automatic model_step();
        int li, lt, ui, ut;
        bit h;
        if (!rst) begin
            for (int m = 0; m < 4; m++) begin
                for (int i = 0; i < 16; i++) begin
                    m_valid[m][i] = 0; m_tag[m][i] = 0; m_tgt[m][i] = 0; m_lvl[m][i] = 0;
                end
                e_hit[m] = 0; e_taken[m] = 0; e_tgt[m] = 0;
            end
            e_miss = 0;
            return;
        end
        if (stall) return;
        li = int'(lk_pc / 4) % 16;  lt = int'(lk_pc / 64) % 256;
        ui = int'(upd_pc / 4) % 16; ut = int'(upd_pc / 64) % 256;
        for (int m = 0; m < 4; m++) begin
            h = lk_valid && (m != 0) && m_valid[m][li] && (m_tag[m][li] == lt);
            e_hit[m]   = h;
            e_taken[m] = h && (m_lvl[m][li] >= 2);
            e_tgt[m]   = h ? m_tgt[m][li] : 32'd0;
            if (upd_valid && m != 0) begin
                if (m_valid[m][ui] && m_tag[m][ui] == ut) begin
                    m_lvl[m][ui] = next_level(m, m_lvl[m][ui], upd_taken);
                    if (upd_taken) m_tgt[m][ui] = upd_target;
                end else if (upd_taken) begin
                    m_valid[m][ui] = 1; m_tag[m][ui] = ut; m_tgt[m][ui] = upd_target;
                    m_lvl[m][ui] = (m == 1) ? 3 : 2;
                end
            end
        end
        if (upd_valid && upd_mispredict && e_miss < 65535) e_miss++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (d_hit[k] !== e_hit[k] || d_taken[k] !== e_taken[k] ||
                d_tgt[k] !== e_tgt[k] || d_miss[k] !== 16'(e_miss)) begin
                n_fail++;
                $display("FAIL model mode%0d t=%0t got hit=%b tk=%b tgt=%h miss=%h exp hit=%b tk=%b tgt=%h miss=%h",
                         k, $time, d_hit[k], d_taken[k], d_tgt[k], d_miss[k],
                         e_hit[k], e_taken[k], e_tgt[k], 16'(e_miss));
            end
        end
    endtask

    typedef struct {
        bit          r, s, lv;
        logic [31:0] lp;
        bit          uv;
        logic [31:0] up;
        bit          ut;
        logic [31:0] utg;
        bit          um;
        bit          eh, et;
        logic [31:0] etg;
        int          em;
    } vec_t;

    vec_t vq[$];

    task automatic add(bit r, bit s, bit lv, logic [31:0] lp, bit uv, logic [31:0] up,
                       bit ut, logic [31:0] utg, bit um, bit eh, bit et,
                       logic [31:0] etg, int em);
        vec_t v;
        v.r = r; v.s = s; v.lv = lv; v.lp = lp; v.uv = uv; v.up = up; v.ut = ut;
        v.utg = utg; v.um = um; v.eh = eh; v.et = et; v.etg = etg; v.em = em;
        vq.push_back(v);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) p = p | ($urandom_range(1, 7) << 20);
        return p;
    endfunction

    initial begin
        // Expected outputs below are for the MODE 2 instance.
        //   r s lv lk_pc      uv up       ut tgt       um  hit tk  tgt       miss
        add(0,0,1, 32'h40,     0, 32'h0,  0, 32'h0,   0,  0, 0, 32'h0,   0);
        add(1,0,1, 32'h40,     0, 32'h0,  0, 32'h0,   0,  0, 0, 32'h0,   0);
        add(1,0,1, 32'h40,     1, 32'h40, 1, 32'h100, 0,  0, 0, 32'h0,   0);
        add(1,0,1, 32'h40,     0, 32'h0,  0, 32'h0,   0,  1, 1, 32'h100, 0);
        add(1,0,0, 32'h40,     1, 32'h40, 0, 32'h0,   0,  0, 0, 32'h0,   0);
        add(1,0,1, 32'h40,     1, 32'h40, 0, 32'h0,   0,  1, 0, 32'h100, 0);
        add(1,0,1, 32'h40,     0, 32'h0,  0, 32'h0,   0,  1, 0, 32'h100, 0);
        add(1,0,1, 32'h40,     1, 32'h40, 1, 32'h100, 0,  1, 0, 32'h100, 0);
        add(1,0,1, 32'h40,     1, 32'h40, 1, 32'h100, 0,  1, 0, 32'h100, 0);
        add(1,0,1, 32'h40,     0, 32'h0,  0, 32'h0,   0,  1, 1, 32'h100, 0);
        add(1,0,1, 32'h80,     0, 32'h0,  0, 32'h0,   0,  0, 0, 32'h0,   0);
        add(1,0,1, 32'h80,     1, 32'h80, 1, 32'h200, 1,  0, 0, 32'h0,   1);
        add(1,0,1, 32'h40,     0, 32'h0,  0, 32'h0,   0,  0, 0, 32'h0,   1);
        add(1,0,1, 32'h80,     0, 32'h0,  0, 32'h0,   0,  1, 1, 32'h200, 1);
        add(1,1,1, 32'h40,     1, 32'h80, 0, 32'h0,   1,  1, 1, 32'h200, 1);
        add(1,0,1, 32'h80,     0, 32'h0,  0, 32'h0,   0,  1, 1, 32'h200, 1);
        add(0,0,1, 32'h80,     1, 32'h80, 1, 32'h300, 1,  0, 0, 32'h0,   0);
        add(1,0,1, 32'h80,     0, 32'h0,  0, 32'h0,   0,  0, 0, 32'h0,   0);

        foreach (vq[i]) begin
            rst = vq[i].r; stall = vq[i].s; lk_valid = vq[i].lv; lk_pc = vq[i].lp;
            upd_valid = vq[i].uv; upd_pc = vq[i].up; upd_taken = vq[i].ut;
            upd_target = vq[i].utg; upd_mispredict = vq[i].um;
            cycle();
            n_checks++;
            if (d_hit[2] !== vq[i].eh || d_taken[2] !== vq[i].et ||
                d_tgt[2] !== vq[i].etg || d_miss[2] !== 16'(vq[i].em)) begin
                n_fail++;
                $display("FAIL vec%0d got hit=%b tk=%b tgt=%h miss=%h exp hit=%b tk=%b tgt=%h miss=%h",
                         i, d_hit[2], d_taken[2], d_tgt[2], d_miss[2],
                         vq[i].eh, vq[i].et, vq[i].etg, 16'(vq[i].em));
            end
        end

        // MODE 3: a single not-taken from weak-taken drops to strong not-taken.
        rst = 1; stall = 0; lk_valid = 0; upd_mispredict = 0;
        upd_valid = 1; upd_pc = 32'h44; upd_taken = 1; upd_target = 32'h500; cycle();
        upd_taken = 0; cycle();
        upd_valid = 0; upd_taken = 1; cycle();
        upd_valid = 1; lk_valid = 1; lk_pc = 32'h44; cycle();
        n_checks++;
        if (d_taken[3] !== 1'b0 || d_hit[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL mode3_hyst got hit=%b tk=%b exp hit=1 tk=0", d_hit[3], d_taken[3]);
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            stall = ($urandom_range(0, 7) == 0);
            lk_valid = ($urandom_range(0, 3) != 0);
            lk_pc = rand_pc();
            upd_valid = ($urandom_range(0, 1) == 0);
            upd_pc = ($urandom_range(0, 2) == 0) ? lk_pc : rand_pc();
            upd_taken = $urandom_range(0, 1);
            upd_target = {$urandom_range(0, 65535), 16'h0} | (32'($urandom_range(0, 63)) << 2);
            upd_mispredict = $urandom_range(0, 1);
            cycle();
        end

        // Drive the mispredict counter past its saturation point.
        rst = 1; stall = 0; lk_valid = 0; upd_valid = 1; upd_pc = 32'h48;
        upd_taken = 0; upd_mispredict = 1;
        for (int i = 0; i < 65540; i++) cycle();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (d_miss[k] !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL miss_sat mode%0d got %h exp ffff", k, d_miss[k]);
            end
        end

        rst = 0; cycle();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (d_miss[k] !== 16'h0 || d_hit[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid mode%0d got miss=%h hit=%b exp 0", k, d_miss[k], d_hit[k]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predict_table.md
Name: branch_predict_table

Overview:
- Parametrised branch predictor for the IF stage, replacing the single global 2-bit predictor state.
- Holds ENTRIES direct-mapped entries, each with a valid bit, tag, branch target and 2-bit counter, indexed by fetch PC.
- Gives a registered taken/target prediction to IF and is trained by ID-stage branch resolution.
- Selectable prediction mode and a saturating mispredict counter.

Parameters:
- ENTRIES, 16, table depth; power of 2, >=2
- IDX_W, 4, log2(ENTRIES)
- TAG_W, 8, tag width; IDX_W+TAG_W <= 30
- MODE, 2, 0 = static not-taken, 1 = 1-bit, 2 = 2-bit saturating, 3 = 2-bit hysteresis

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous active-low reset
- stall  in  1  pipeline stall; freezes all state and outputs
- lk_valid  in  1  lookup request this cycle
- lk_pc  in  32  fetch PC to predict
- pred_hit  out  1  registered: lookup matched a valid entry
- pred_taken  out  1  registered: predict taken
- pred_target  out  32  registered: predicted target (0 when no hit)
- upd_valid  in  1  resolved branch in ID this cycle
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target
- upd_mispredict  in  1  ID detected misprediction
- miss_count  out  16  saturating mispredict count

Behaviour:
- Reset (rst==0 at posedge, overrides everything, including mid-operation):
  - all valid=0, tags/targets=0, counters=2'b11 (strong not-taken)
  - pred_hit=0, pred_taken=0, pred_target=0, miss_count=0
- Address slicing:
  - idx = pc[IDX_W+1:2]
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2]
  - hit = valid[idx] & (tag matches)
- Counter encoding: 00 strong taken, 01 weak taken, 10 weak not-taken, 11 strong not-taken. Predict taken iff hit & counter[1]==0.
- Lookup (1-cycle latency):
  - At posedge with stall=0 and lk_valid=1: pred_hit <= hit; pred_taken <= hit & ~ctr[1]; pred_target <= hit ? target : 0.
  - lk_valid=0 and stall=0: all three outputs <= 0.
  - stall=1: outputs hold.
- Update (applied at posedge when upd_valid=1 and stall=0; ignored when stall=1):
  - Hit:
    - counter moves per MODE.
    - If upd_taken, target <= upd_target.
  - Miss with upd_taken=1: allocate (overwrite) the entry.
    - valid <= 1, tag and target written.
    - counter <= 01 for MODE 2/3, 00 for MODE 1.
  - Miss with upd_taken=0: no change.
- Counter transitions per MODE (T = taken, N = not-taken):
  - MODE 1: T -> 00, N -> 11
  - MODE 2: 00 T00/N01; 01 T00/N10; 10 T01/N11; 11 T10/N11
  - MODE 3: 00 T00/N01; 01 T00/N11; 10 T00/N11; 11 T10/N11 (miss in a weak state jumps to the opposite strong state)
- MODE 0: table never written; pred_hit=pred_taken=pred_target=0 always; miss_count still counts.
- Same-cycle lookup and update to the same idx: lookup returns pre-update contents (read-before-write). The update is visible from the next lookup.
- miss_count increments when upd_valid & upd_mispredict & ~stall; saturates at 16'hFFFF with no wrap.
- Implementation: 120–400 lines of RTL; counter array and target array sized from the parameters.

Test Plan:
- Reset then lk_pc=0x40, lk_valid=1 -> next cycle pred_hit=0, pred_taken=0, pred_target=0, miss_count=0.
- Allocation (MODE 2): upd pc=0x40, taken=1, target=0x100 -> following lookup 0x40 gives pred_hit=1, pred_taken=1, pred_target=0x100 (counter 01).
- Training (MODE 2 from 01):
  - N, N -> ctr 11, pred_taken=0
  - T -> 10, pred_taken=0
  - T -> 01, pred_taken=1
  - Same start in MODE 3: one N -> 11 immediately.
- Aliasing: allocate 0x40, then lookup 0x80 (same idx 0, tag 2 vs 1) -> pred_hit=0. Taken update at 0x80 evicts 0x40; lookup 0x40 -> pred_hit=0.
- Stall and collision:
  - stall=1 with upd_valid=1 -> no table change; pred_* hold.
  - Same-idx lookup + update in one cycle -> old prediction returned, new one on next lookup.
- Counter and reset:
  - Preload so 0x10000 mispredicts have occurred -> miss_count=0xFFFF.
  - rst=0 mid-sequence -> everything zero/11 on the next edge.
